// File: rtl/dla_cdc_handshake_tx.sv
// Transmit end of a 4-phase req/ack clock crossing.
// A word is taken over a valid/ready port, held on o_data and announced with
// a registered o_req. The asynchronous acknowledge passes through a
// metastability chain before it is used.
module dla_cdc_handshake_tx #(
  parameter int DATA_WIDTH           = 32,
  parameter int METASTABILITY_STAGES = 3
) (
  input  logic                  clk,
  input  logic                  i_async_resetn,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                          state_r;
  state_t                          state_nxt;
  logic [METASTABILITY_STAGES-1:0] sync_r;
  logic                            ack_sync;
  logic                            req_r;
  logic                            req_nxt;
  logic                            busy_r;
  logic                            busy_nxt;
  logic                            done_r;
  logic                            done_nxt;
  logic                            load;
  logic                            accept;
  logic [DATA_WIDTH-1:0]           data_r;

  assign ack_sync = sync_r[METASTABILITY_STAGES-1];

  // A stale acknowledge still high in IDLE holds off the next word.
  assign o_ready = (state_r == ST_IDLE) && !ack_sync;
  assign accept  = i_valid && o_ready;

  assign o_req  = req_r;
  assign o_data = data_r;
  assign o_busy = busy_r;
  assign o_done = done_r;

  // Metastability chain for the foreign-domain acknowledge.
  always_ff @(posedge clk or negedge i_async_resetn) begin
    if (!i_async_resetn) begin
      sync_r <= {METASTABILITY_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[METASTABILITY_STAGES-2:0], i_ack};
    end
  end

  // Next-state and next-output decode; protocol-illegal ack edges are ignored.
  always_comb begin
    state_nxt = state_r;
    req_nxt   = 1'b0;
    done_nxt  = 1'b0;
    load      = 1'b0;
    busy_nxt  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          load      = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_sync) begin
          state_nxt = ST_RELEASE;
          req_nxt   = 1'b0;
        end else begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!ack_sync) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = ST_RELEASE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk or negedge i_async_resetn) begin
    if (!i_async_resetn) begin
      state_r <= ST_IDLE;
      req_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      req_r   <= req_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
    end
  end

  // Captured word; only an accept changes it, so it is stable for the whole
  // 4-phase cycle the receiver may sample it in.
  always_ff @(posedge clk or negedge i_async_resetn) begin
    if (!i_async_resetn) begin
      data_r <= {DATA_WIDTH{1'b0}};
    end else if (load) begin
      data_r <= i_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: tb/tb_dla_cdc_handshake_tx.sv
// Self-checking bench for dla_cdc_handshake_tx. Loopback traffic is predicted
// from the handshake timeline (accept time plus fixed offsets); directed
// sequences cover delayed ack, stale ack after reset and mid-transfer reset.
module tb_dla_cdc_handshake_tx;

  localparam int DW = 32;
  localparam int S  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          req;
  logic [DW-1:0] odata;
  logic          i_ack;
  logic          busy;
  logic          done;
  logic          ack_drv;
  logic          loop_en;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] model_data;
  logic [DW-1:0] w;

  assign i_ack = loop_en ? req : ack_drv;

  dla_cdc_handshake_tx #(
    .DATA_WIDTH(DW),
    .METASTABILITY_STAGES(S)
  ) dut (
    .clk(clk),
    .i_async_resetn(rst_n),
    .i_valid(valid),
    .o_ready(ready),
    .i_data(data),
    .o_req(req),
    .o_data(odata),
    .i_ack(i_ack),
    .o_busy(busy),
    .o_done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_ready, input logic e_req,
                            input logic e_busy, input logic e_done, input logic [DW-1:0] e_data);
    check_eq({tag, ".ready"}, 64'(ready), 64'(e_ready));
    check_eq({tag, ".req"},   64'(req),   64'(e_req));
    check_eq({tag, ".busy"},  64'(busy),  64'(e_busy));
    check_eq({tag, ".done"},  64'(done),  64'(e_done));
    check_eq({tag, ".data"},  64'(odata), 64'(e_data));
  endtask

  // Loopback traffic: an accept at edge a gives req high after edges a..a+3,
  // busy after a..a+7, done and ready after a+8; next accept at a+9 or later.
  task automatic run_loop(input int ncyc, input int vpct, input bit fixed_en,
                          input logic [DW-1:0] fixed_w);
    int last_acc;
    int d;
    bit pend;
    bit acc;
    last_acc = -1000;
    pend     = 1'b0;
    loop_en  = 1'b1;
    for (int n = 1; n <= ncyc + 9; n++) begin
      if (n <= ncyc) begin
        if (!pend) begin
          valid = ($urandom_range(99) < vpct);
          data  = fixed_en ? fixed_w : DW'($urandom);
        end
      end else begin
        valid = 1'b0;
      end
      step();
      acc = valid && ((n - 1) >= last_acc + 8);
      if (acc) begin
        last_acc   = n;
        model_data = data;
      end
      pend = valid && !acc;
      d    = n - last_acc;
      check_outs("loop", d >= 8, d <= 3, d <= 7, d == 8, model_data);
    end
    valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    valid      = 1'b0;
    data       = '0;
    ack_drv    = 1'b0;
    loop_en    = 1'b1;
    model_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      step();
      check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    end

    // Single word, then valid held high with 4 words, then random traffic.
    run_loop(9, 100, 1'b1, 32'hA5A5_0001);
    run_loop(36, 100, 1'b0, 32'h0000_0000);
    run_loop(400, 40, 1'b0, 32'h0000_0000);

    // Far side acks 50 cycles after req and holds ack for 30 cycles.
    loop_en = 1'b0;
    ack_drv = 1'b0;
    valid   = 1'b1;
    data    = DW'($urandom);
    w       = data;
    step();
    valid      = 1'b0;
    model_data = w;
    check_outs("dly_acc", 1'b0, 1'b1, 1'b1, 1'b0, w);
    for (int i = 0; i < 49; i++) begin
      step();
      check_outs("dly_wait", 1'b0, 1'b1, 1'b1, 1'b0, w);
    end
    ack_drv = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check_outs("dly_ackhi", 1'b0, k <= 3, 1'b1, 1'b0, w);
    end
    ack_drv = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_outs("dly_acklo", k >= 4, 1'b0, k < 4, k == 4, w);
    end

    // Reset released while the far side still acks.
    #1 rst_n = 1'b0;
    model_data = '0;
    ack_drv    = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    w     = DW'($urandom);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k >= 3) begin
        check_outs("stale_hi", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      end
      if (k == 3) begin
        valid = 1'b1;
        data  = w;
      end
    end
    ack_drv = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k <= 2) begin
        check_outs("stale_lo", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      end else if (k == 3) begin
        check_outs("stale_rdy", 1'b1, 1'b0, 1'b0, 1'b0, '0);
      end else begin
        check_outs("stale_acc", 1'b0, 1'b1, 1'b1, 1'b0, w);
      end
    end
    valid      = 1'b0;
    model_data = w;
    loop_en    = 1'b1;
    repeat (12) step();
    check_outs("stale_end", 1'b1, 1'b0, 1'b0, 1'b0, w);

    // Asynchronous reset while in REQ.
    valid = 1'b1;
    data  = DW'($urandom);
    w     = data;
    step();
    valid = 1'b0;
    check_outs("rreq_acc", 1'b0, 1'b1, 1'b1, 1'b0, w);
    step();
    check_eq("rreq_hold.req", 64'(req), 64'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("rreq_async.req",  64'(req),   64'(1'b0));
    check_eq("rreq_async.busy", 64'(busy),  64'(1'b0));
    check_eq("rreq_async.data", 64'(odata), 64'(0));
    check_eq("rreq_async.done", 64'(done),  64'(1'b0));
    model_data = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_outs("rreq_rel", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_loop(20, 100, 1'b0, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
